// File: rtl/mem_bus_pkg.sv
// Shared types and default widths for the fetch/data memory bus arbiter.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_e;

endpackage

// File: rtl/mem_bus_grant.sv
// Combinational grant select, zero latency, no backpressure; a lone requester always wins.
// Ties: data port by default, or the port not granted last when BUS_ROUND_ROBIN_EN is defined.
module mem_bus_grant
  import mem_bus_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  req_e last_grant,
  output req_e winner
);

`ifndef BUS_ROUND_ROBIN_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    winner = REQ_D;
    if (if_req && !d_req) begin
      winner = REQ_IF;
    end else if (if_req && d_req) begin
`ifdef BUS_ROUND_ROBIN_EN
      winner = (last_grant == REQ_IF) ? REQ_D : REQ_IF;
`else
      winner = REQ_D;
`endif
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one single-outstanding bus: IDLE->ISSUE->RESP, valid 3 cycles after request.
// waitrequest stalls ISSUE with all bus outputs held; tie policy via BUS_ROUND_ROBIN_EN (see mem_bus_grant).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic                  write,
  output logic [DATA_W-1:0]     writedata,
  output logic [DATA_W/8-1:0]   byteenable,
  input  logic                  waitrequest,
  input  logic [DATA_W-1:0]     readdata
);

  localparam int BE_W = DATA_W / 8;

  state_e              state_q, state_d;
  req_e                win_q, win_d;
  req_e                ptr_q, ptr_d;
  req_e                grant_win;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                any_req;

  assign any_req = if_req | d_req;

  mem_bus_grant u_grant (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_grant (ptr_q),
    .winner     (grant_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (!waitrequest) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are captured only on the grant edge, so they stay frozen through any stall.
  always_comb begin
    win_d      = win_q;
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (state_q == IDLE && any_req) begin
      win_d = grant_win;
      ptr_d = grant_win;
      if (grant_win == REQ_IF) begin
        addr_d  = if_addr;
        we_d    = 1'b0;
        wdata_d = '0;
        be_d    = '1;
      end else begin
        addr_d  = d_addr;
        we_d    = d_we;
        wdata_d = d_wdata;
        be_d    = d_be;
      end
    end
    if (state_q == RESP) begin
      if (win_q == REQ_IF) begin
        if_rdata_d = readdata;
      end else begin
        d_rdata_d = we_q ? '0 : readdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q      <= REQ_D;
      ptr_q      <= REQ_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    read       = (state_q == ISSUE) && !we_q;
    write      = (state_q == ISSUE) && we_q;
    if_valid   = (state_q == RESP) && (win_q == REQ_IF);
    d_valid    = (state_q == RESP) && (win_q == REQ_D);
    address    = addr_q;
    writedata  = wdata_q;
    byteenable = be_q;
    // readdata is only valid in the RESP cycle, so it is forwarded there and registered for later.
    if_rdata   = if_valid ? readdata : if_rdata_q;
    d_rdata    = d_rdata_q;
    if (d_valid) begin
      d_rdata = we_q ? '0 : readdata;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expected completions queued at request time, popped on valid.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_vld = 0;

  localparam logic [31:0] IDLE_DATA = 32'h5A5A5A5A;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_be        (d_be),
    .d_rdata     (d_rdata),
    .d_valid     (d_valid),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h24020001;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Bus slave: read data appears exactly one cycle after an accepted read.
  initial begin : responder
    logic        acc;
    logic [31:0] acc_a;
    readdata = IDLE_DATA;
    forever begin
      @(negedge clk);
      #1;
      acc   = read && !waitrequest && !reset;
      acc_a = address;
      @(posedge clk);
      #1;
      readdata = acc ? mem_word(acc_a) : IDLE_DATA;
    end
  end

  initial begin : monitor
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (if_valid || d_valid) begin
        n_vld++;
        n_chk++;
        if (if_valid && d_valid) begin
          n_fail++;
          $display("FAIL both_valid: if_valid=1 d_valid=1, required only one");
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_valid: if_valid=%0b d_valid=%0b, required no completion", if_valid, d_valid);
        end else begin
          e   = sb.pop_front();
          got = if_valid ? if_rdata : d_rdata;
          if (e.is_if != if_valid || got !== e.data) begin
            n_fail++;
            $display("FAIL completion: port_if=%0b data=%h, required port_if=%0b data=%h", if_valid, got, e.is_if, e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input bit is_if, input logic [31:0] data);
    exp_t e;
    e.is_if = is_if;
    e.data  = data;
    sb.push_back(e);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset       = 1'b1;
    if_req      = 1'b0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({read, write, if_valid, d_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: rd/wr/ifv/dv=%b, required 0000", {read, write, if_valid, d_valid});
    end
    n_chk++;
    if ({address, writedata, byteenable} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%h wdata=%h be=%h, required 0", address, writedata, byteenable);
    end
    n_chk++;
    if ({if_rdata, d_rdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h, required 0", if_rdata, d_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_lone_fetch;
    do_reset();
    if_addr = 32'hBFC00000;
    if_req  = 1'b1;
    push_exp(1'b1, 32'h24020001);
    @(negedge clk);
    n_chk++;
    if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'hBFC00000, 4'hF}) begin
      n_fail++;
      $display("FAIL fetch_issue: rd=%b wr=%b addr=%h be=%h, required 1 0 bfc00000 f", read, write, address, byteenable);
    end
    @(negedge clk);
    n_chk++;
    if ({if_valid, d_valid, read, write} !== 4'b1000 || if_rdata !== 32'h24020001) begin
      n_fail++;
      $display("FAIL fetch_resp: ifv/dv/rd/wr=%b rdata=%h, required 1000 24020001", {if_valid, d_valid, read, write}, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({if_valid, read} !== 2'b00 || if_rdata !== 32'h24020001) begin
      n_fail++;
      $display("FAIL fetch_hold: ifv=%b rd=%b rdata=%h, required 0 0 24020001", if_valid, read, if_rdata);
    end
  endtask

  task automatic test_write_stall;
    do_reset();
    d_addr      = 32'hBFC00010;
    d_wdata     = 32'hDEADBEEF;
    d_be        = 4'b0011;
    d_we        = 1'b1;
    d_req       = 1'b1;
    waitrequest = 1'b1;
    push_exp(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({read, write, address, writedata, byteenable} !== {1'b0, 1'b1, 32'hBFC00010, 32'hDEADBEEF, 4'b0011}) begin
        n_fail++;
        $display("FAIL write_stall_c%0d: rd=%b wr=%b addr=%h wd=%h be=%b, required 0 1 bfc00010 deadbeef 0011",
                 i + 1, read, write, address, writedata, byteenable);
      end
      if (i == 3) waitrequest = 1'b0;
    end
    @(negedge clk);
    n_chk++;
    if ({d_valid, if_valid, write, read} !== 4'b1000 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL write_resp: dv/ifv/wr/rd=%b d_rdata=%h, required 1000 00000000", {d_valid, if_valid, write, read}, d_rdata);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    n_chk++;
    if (d_valid !== 1'b0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL write_single_pulse: dv=%b d_rdata=%h, required 0 00000000", d_valid, d_rdata);
    end
  endtask

  task automatic test_tie;
    bit first_if;
    int if_cyc;
    int d_cyc;
`ifdef BUS_ROUND_ROBIN_EN
    first_if = 1'b1;
`else
    first_if = 1'b0;
`endif
    do_reset();
    if_addr = 32'h00002000;
    d_addr  = 32'h00003000;
    d_we    = 1'b0;
    d_be    = 4'hF;
    if_req  = 1'b1;
    d_req   = 1'b1;
    push_exp(first_if, mem_word(first_if ? if_addr : d_addr));
    push_exp(!first_if, mem_word(first_if ? d_addr : if_addr));
    if_cyc = -1;
    d_cyc  = -1;
    for (int c = 1; c <= 20 && (if_cyc < 0 || d_cyc < 0); c++) begin
      @(negedge clk);
      if (if_valid) begin
        if_cyc = c;
        if_req = 1'b0;
      end
      if (d_valid) begin
        d_cyc = c;
        d_req = 1'b0;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    n_chk++;
    if (if_cyc != (first_if ? 2 : 5) || d_cyc != (first_if ? 5 : 2)) begin
      n_fail++;
      $display("FAIL tie_order: if_valid cycle=%0d d_valid cycle=%0d, required %0d %0d",
               if_cyc, d_cyc, first_if ? 2 : 5, first_if ? 5 : 2);
    end
  endtask

  task automatic test_both_held;
    int  nv;
    bit  exp_if;
    do_reset();
    if_addr = 32'h00005000;
    d_addr  = 32'h00006000;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef BUS_ROUND_ROBIN_EN
      exp_if = (k % 2 == 0);
`else
      exp_if = 1'b0;
`endif
      push_exp(exp_if, mem_word(exp_if ? if_addr : d_addr));
    end
    nv = 0;
    for (int c = 1; c <= 30 && nv < 4; c++) begin
      @(negedge clk);
      if (if_valid || d_valid) begin
`ifdef BUS_ROUND_ROBIN_EN
        exp_if = (nv % 2 == 0);
`else
        exp_if = 1'b0;
`endif
        n_chk++;
        if (c != 2 + 3 * nv || if_valid != exp_if) begin
          n_fail++;
          $display("FAIL both_held_grant%0d: cycle=%0d if_won=%0b, required cycle=%0d if_won=%0b",
                   nv, c, if_valid, 2 + 3 * nv, exp_if);
        end
        nv++;
        if (nv == 4) begin
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    n_chk++;
    if (nv != 4) begin
      n_fail++;
      $display("FAIL both_held_count: completions=%0d, required 4", nv);
    end
  endtask

  task automatic test_back_to_back;
    int          nv;
    logic [31:0] a;
    do_reset();
    a       = 32'h00001000;
    if_addr = a;
    if_req  = 1'b1;
    push_exp(1'b1, mem_word(a));
    nv = 0;
    for (int c = 1; c <= 40 && nv < 4; c++) begin
      @(negedge clk);
      if (if_valid) begin
        n_chk++;
        if (c != 2 + 3 * nv || if_rdata !== mem_word(a)) begin
          n_fail++;
          $display("FAIL b2b_fetch%0d: cycle=%0d rdata=%h, required cycle=%0d rdata=%h",
                   nv, c, if_rdata, 2 + 3 * nv, mem_word(a));
        end
        nv++;
        if (nv < 4) begin
          a       = a + 32'd4;
          if_addr = a;
          push_exp(1'b1, mem_word(a));
        end else begin
          if_req = 1'b0;
        end
      end
    end
    if_req = 1'b0;
    n_chk++;
    if (nv != 4) begin
      n_fail++;
      $display("FAIL b2b_count: completions=%0d, required 4", nv);
    end
  endtask

  task automatic test_reset_mid;
    int v0;
    do_reset();
    d_addr      = 32'h00004000;
    d_we        = 1'b0;
    d_req       = 1'b1;
    waitrequest = 1'b1;
    @(negedge clk);
    n_chk++;
    if (read !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: rd=%b, required 1", read);
    end
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({read, write, if_valid, d_valid} !== 4'b0000 || address !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_after: rd/wr/ifv/dv=%b addr=%h, required 0000 00000000", {read, write, if_valid, d_valid}, address);
    end
    reset       = 1'b0;
    d_req       = 1'b0;
    waitrequest = 1'b0;
    v0 = n_vld;
    repeat (4) @(negedge clk);
    n_chk++;
    if (n_vld != v0 || read !== 1'b0 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_abandon: valids=%0d rd=%b d_rdata=%h, required 0 0 00000000", n_vld - v0, read, d_rdata);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    if_req      = 1'b0;
    if_addr     = 32'h0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_addr      = 32'h0;
    d_wdata     = 32'h0;
    d_be        = 4'h0;
    waitrequest = 1'b0;
    test_reset();
    test_lone_fetch();
    test_write_stall();
    test_tie();
    test_both_held();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 32, bus/requester address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_valid  out  1  fetch completion pulse.
- d_req  in  1  data-access request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_be  in  DATA_W/8  data byte enables.
- d_rdata  out  DATA_W  data read data.
- d_valid  out  1  data completion pulse.
- address  out  ADDR_W  bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- writedata  out  DATA_W  bus write data.
- byteenable  out  DATA_W/8  bus byte enables.
- waitrequest  in  1  bus stall; the current strobe is held while it is high.
- readdata  in  DATA_W  bus read data, valid exactly 1 cycle after acceptance.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and RESP.
- IDLE -> ISSUE when any request is high.
- ISSUE -> RESP when waitrequest is low.
- ISSUE holds while waitrequest is high.
- RESP -> IDLE unconditionally.

REQ-004 On the IDLE->ISSUE edge, the arbiter SHALL register the winner's address, we, wdata and byteenable into the bus output registers. Fetch transactions use byteenable = all ones and write = 0.

REQ-005 In ISSUE, exactly one of read/write SHALL be high. All bus outputs SHALL stay stable until the cycle after waitrequest is sampled low.

REQ-006 read and write SHALL be low in IDLE and RESP.

REQ-007 In RESP, the winner's valid SHALL be high for exactly one cycle.
- Read: the winner's rdata equals readdata in that cycle, and is held in a register afterwards.
- Write: d_rdata reads 0.

REQ-008 The non-winning valid SHALL be 0 at all times.

REQ-009 Latency SHALL be 3 cycles from a request sampled in IDLE to valid, with zero wait states. Each waitrequest cycle adds exactly 1 cycle.

REQ-010 Requester contract:
- req and its fields are held stable until valid.
- req is deasserted at the edge ending the valid cycle, unless a new request is issued.
- A request still high in IDLE is a new transaction (back-to-back permitted).

REQ-011 When if_req and d_req are both high in IDLE, arbitration SHALL follow REQ-016. A lone requester SHALL always win.

REQ-012 A request arriving during ISSUE or RESP SHALL wait, never preempt, and be arbitrated in the next IDLE.

Reset
REQ-013 When reset is high at a posedge:
- FSM -> IDLE.
- Round-robin pointer -> data port (so the fetch port wins the first tie).
- Outputs read, write, if_valid, d_valid = 0.
- Outputs address, writedata, byteenable, if_rdata, d_rdata = 0.

REQ-014 Reset mid-transaction SHALL abandon it. No valid is issued for it, and strobes are low in the cycle after reset.

Configuration
REQ-015 Without BUS_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with the data port winning ties.

REQ-016 With BUS_ROUND_ROBIN_EN, ties SHALL go to the port not granted last. The pointer updates on every grant.

Structure
REQ-017 Package mem_bus_pkg SHALL hold:
- the FSM state enum (IDLE/ISSUE/RESP);
- the requester enum (REQ_IF/REQ_D);
- default ADDR_W/DATA_W constants.

REQ-018 Grant selection SHALL live in one combinational sub-module, mem_bus_grant (inputs: both reqs and the pointer; output: the winner). All sequential logic SHALL stay in mem_bus_arbiter.

Verification
REQ-019 Lone fetch: if_addr=32'hBFC00000, zero wait states, readdata=32'h24020001 -> read high in cycle 1; if_valid in cycle 2 with if_rdata=32'h24020001.

REQ-020 Data write under stall: d_we=1, d_addr=32'hBFC00010, d_wdata=32'hDEADBEEF, d_be=4'b0011, waitrequest high 3 cycles -> write and all bus fields stable for 4 cycles; d_valid pulses once; d_rdata=0.

REQ-021 Simultaneous if_req/d_req, macro off -> data served first, fetch next; 6 cycles total with zero waits.

REQ-022 Both requests held continuously for 4 transactions, macro on -> grants alternate IF,D,IF,D.

REQ-023 Reset asserted during ISSUE with waitrequest high -> next cycle read=0, write=0, FSM IDLE, no valid pulse.

REQ-024 Back-to-back fetches (if_req kept high, addresses +4) -> one transaction per 3 cycles; each if_valid matches its readdata.
